vector_operand_collector: RTL and testbench

//  Read-side requester for the banked vector register file: accepts one issued

---
 rtl/vector_operand_collector.sv | 178 +++++++++++++++++
 tb/tb_vector_operand_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_operand_collector.sv
// Operand collector for the banked vector register file: issues up to three source
// reads plus the v0 mask, serialises bank conflicts, presents one operand set.
module vector_operand_collector #(
    parameter int XLEN       = 32,
    parameter int NUM_THREAD = 32,
    parameter int NUM_BANK   = 4,
    parameter int REG_IDX_W  = 10,
    parameter int TAG_W      = 8,
    localparam int OPW       = XLEN * NUM_THREAD,
    localparam int BANK_W    = $clog2(NUM_BANK),
    localparam int ROW_W     = REG_IDX_W - BANK_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3*REG_IDX_W-1:0]    in_rs_idx,
    input  logic [2:0]                in_rs_en,
    input  logic                      in_mask_en,
    input  logic [TAG_W-1:0]          in_tag,
    output logic [NUM_BANK*ROW_W-1:0] bank_rsidx_o,
    output logic [NUM_BANK-1:0]       bank_rsren_o,
    input  logic [NUM_BANK*OPW-1:0]   bank_rs_i,
    input  logic [OPW-1:0]            bank_v0_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3*OPW-1:0]          out_rs,
    output logic [OPW-1:0]            out_v0,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int NSRC = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [BANK_W-1:0]   src_bank_q  [NSRC];
    logic [ROW_W-1:0]    src_row_q   [NSRC];
    logic [NSRC-1:0]     pending_q;
    logic                mask_en_q;
    logic                first_q;
    logic [TAG_W-1:0]    tag_q;
    logic [NSRC-1:0]     sel_vld_p1;
    logic [BANK_W-1:0]   sel_bank_p1 [NSRC];
    logic [OPW-1:0]      rs_q        [NSRC];
    logic [OPW-1:0]      v0_q;

    logic [NSRC-1:0]     grant;
    logic [NUM_BANK-1:0] rd_en;
    logic [ROW_W-1:0]    rd_row      [NUM_BANK];
    logic [OPW-1:0]      bank_rd     [NUM_BANK];
    logic                issue_act;
    logic                capture_act;

    assign issue_act   = rst_n && (state_q == S_ISSUE);
    assign capture_act = (state_q == S_ISSUE) || (state_q == S_DRAIN);

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        assign bank_rd[b]                      = bank_rs_i[b*OPW +: OPW];
        assign bank_rsidx_o[b*ROW_W +: ROW_W]  = rd_row[b];
    end

    assign bank_rsren_o = rd_en;
    assign in_ready     = rst_n && (state_q == S_IDLE);
    assign out_valid    = (state_q == S_OUT);
    assign out_rs       = {rs_q[2], rs_q[1], rs_q[0]};
    assign out_v0       = v0_q;
    assign out_tag      = tag_q;

    // Issue stage: one source per bank per cycle, rs1 wins over rs2 over rs3.
    always_comb begin
        logic [NUM_BANK-1:0] busy;
        busy  = '0;
        grant = '0;
        rd_en = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            rd_row[b] = '0;
        end
        if (issue_act) begin
            for (int s = 0; s < NSRC; s++) begin
                if (pending_q[s] && !busy[src_bank_q[s]]) begin
                    grant[s]                = 1'b1;
                    busy[src_bank_q[s]]     = 1'b1;
                    rd_en[src_bank_q[s]]    = 1'b1;
                    rd_row[src_bank_q[s]]   = src_row_q[s];
                end
            end
            // v0 only appears alongside a bank-0 read; force a row-0 read if nobody uses bank 0.
            if (first_q && mask_en_q && !busy[0]) begin
                rd_en[0] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = (in_rs_en == '0 && !in_mask_en) ? S_OUT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((pending_q & ~grant) == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            mask_en_q  <= 1'b0;
            first_q    <= 1'b0;
            tag_q      <= '0;
            sel_vld_p1 <= '0;
            v0_q       <= '0;
            for (int s = 0; s < NSRC; s++) begin
                src_bank_q[s]  <= '0;
                src_row_q[s]   <= '0;
                sel_bank_p1[s] <= '0;
                rs_q[s]        <= '0;
            end
        end else begin
            state_q    <= state_d;
            sel_vld_p1 <= grant;
            for (int s = 0; s < NSRC; s++) begin
                sel_bank_p1[s] <= src_bank_q[s];
            end

            if (state_q == S_IDLE && in_valid) begin
                for (int s = 0; s < NSRC; s++) begin
                    src_bank_q[s] <= in_rs_idx[s*REG_IDX_W +: BANK_W];
                    src_row_q[s]  <= in_rs_idx[s*REG_IDX_W + BANK_W +: ROW_W];
                    rs_q[s]       <= '0;
                end
                pending_q <= in_rs_en;
                mask_en_q <= in_mask_en;
                tag_q     <= in_tag;
                first_q   <= 1'b1;
                v0_q      <= '0;
            end

            if (state_q == S_ISSUE) begin
                pending_q <= pending_q & ~grant;
                first_q   <= 1'b0;
                if (first_q && mask_en_q) begin
                    v0_q <= bank_v0_i;
                end
            end

            // Capture stage: SRAM data returns one cycle after the read was granted.
            if (capture_act) begin
                for (int s = 0; s < NSRC; s++) begin
                    if (sel_vld_p1[s]) begin
                        rs_q[s] <= bank_rd[sel_bank_p1[s]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_operand_collector.sv
// Bench for vector_operand_collector: SRAM bank model with per-instruction contents,
// directed conflict/mask/backpressure/reset cases and randomized instructions.
module tb_vector_operand_collector;

    localparam int OPW = 1024;
    localparam int NB  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [29:0]       in_rs_idx;
    logic [2:0]        in_rs_en;
    logic              in_mask_en;
    logic [7:0]        in_tag;
    logic [31:0]       bank_rsidx_o;
    logic [3:0]        bank_rsren_o;
    logic [NB*OPW-1:0] bank_rs_i;
    logic [OPW-1:0]    bank_v0_i;
    logic              out_valid;
    logic              out_ready;
    logic [3*OPW-1:0]  out_rs;
    logic [OPW-1:0]    out_v0;
    logic [7:0]        out_tag;

    logic [31:0] salt = 32'h0;
    logic [31:0] junk = 32'h1357_9bdf;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [3:0]  log_en  [16];
    logic [31:0] log_idx [16];

    always #5 clk = ~clk;

    vector_operand_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs_idx    (in_rs_idx),
        .in_rs_en     (in_rs_en),
        .in_mask_en   (in_mask_en),
        .in_tag       (in_tag),
        .bank_rsidx_o (bank_rsidx_o),
        .bank_rsren_o (bank_rsren_o),
        .bank_rs_i    (bank_rs_i),
        .bank_v0_i    (bank_v0_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs       (out_rs),
        .out_v0       (out_v0),
        .out_tag      (out_tag)
    );

    // Register-file contents: every (bank,row,lane) word is distinct and changes with salt.
    function automatic logic [OPW-1:0] bank_word(input int b, input int row, input logic [31:0] s);
        logic [OPW-1:0] w;
        for (int l = 0; l < 32; l++) w[l*32 +: 32] = s ^ 32'((b << 28) | (row << 16) | l);
        return w;
    endfunction

    function automatic logic [OPW-1:0] v0_word(input logic [31:0] s);
        logic [OPW-1:0] w;
        for (int l = 0; l < 32; l++) w[l*32 +: 32] = ~s ^ 32'(l << 8);
        return w;
    endfunction

    // Expected cycles from accept edge to first out_valid: one issue cycle per source
    // on the busiest bank (at least one if anything is read), then capture, then OUT.
    function automatic int exp_lat(input logic [29:0] idx, input logic [2:0] en, input logic mk);
        int cnt [4];
        int mx = 0;
        for (int b = 0; b < 4; b++) cnt[b] = 0;
        for (int s = 0; s < 3; s++) if (en[s]) cnt[idx[s*10 +: 2]]++;
        for (int b = 0; b < 4; b++) if (cnt[b] > mx) mx = cnt[b];
        if (en == 3'b000 && !mk) return 1;
        if (mx == 0) mx = 1;
        return mx + 2;
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            bank_rs_i[b*OPW +: OPW] <= bank_rsren_o[b]
                ? bank_word(b, int'(bank_rsidx_o[b*8 +: 8]), salt)
                : {32{junk ^ 32'(b)}};
        junk <= $urandom;
    end

    assign bank_v0_i = bank_rsren_o[0] ? v0_word(salt) : {32{~junk}};

    task automatic check(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else begin
            int lane = 0;
            for (int l = OPW/32 - 1; l >= 0; l--)
                if (got[l*32 +: 32] !== exp[l*32 +: 32]) lane = l;
            $display("FAIL %s: lane %0d got %h expected %h", tag, lane,
                     got[lane*32 +: 32], exp[lane*32 +: 32]);
        end
    endtask

    // Starts and ends at a negedge; returns in cycle T1 (first cycle after accept edge).
    task automatic offer(input logic [9:0] i0, input logic [9:0] i1, input logic [9:0] i2,
                         input logic [2:0] en, input logic mk, input logic [7:0] tg);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_wait", in_ready, 1'b1);
        in_rs_idx  = {i2, i1, i0};
        in_rs_en   = en;
        in_mask_en = mk;
        in_tag     = tg;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        in_rs_idx  = 30'($urandom);
        in_rs_en   = 3'($urandom);
        in_mask_en = 1'($urandom);
        in_tag     = 8'($urandom);
    endtask

    task automatic collect(output int lat);
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            log_en[k]  = '0;
            log_idx[k] = '0;
        end
        for (int k = 1; k < 16; k++) begin
            log_en[k]  = bank_rsren_o;
            log_idx[k] = bank_rsidx_o;
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [9:0] i0, input logic [9:0] i1, input logic [9:0] i2,
                       input logic [2:0] en, input logic mk, input logic [7:0] tg, input int hold);
        logic [29:0]    idx;
        logic [OPW-1:0] e_rs [3];
        logic [OPW-1:0] e_v0;
        int             lat;
        idx  = {i2, i1, i0};
        salt = $urandom;
        for (int s = 0; s < 3; s++)
            e_rs[s] = en[s] ? bank_word(int'(idx[s*10 +: 2]), int'(idx[s*10+2 +: 8]), salt) : '0;
        e_v0 = mk ? v0_word(salt) : '0;
        offer(i0, i1, i2, en, mk, tg);
        collect(lat);
        check("latency", lat, exp_lat(idx, en, mk));
        for (int s = 0; s < 3; s++) check($sformatf("out_rs%0d", s + 1), out_rs[s*OPW +: OPW], e_rs[s]);
        check("out_v0", out_v0, e_v0);
        check("out_tag", out_tag, tg);
        check("in_ready_busy", in_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            for (int s = 0; s < 3; s++) check("hold_rs", out_rs[s*OPW +: OPW], e_rs[s]);
            check("hold_v0", out_v0, e_v0);
            check("hold_tag", out_tag, tg);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_dropped", out_valid, 1'b0);
        check("in_ready_after", in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_rs_idx  = '0;
        in_rs_en   = '0;
        in_mask_en = 1'b0;
        in_tag     = '0;
        out_ready  = 1'b0;

        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_rs", out_rs[OPW-1:0] | out_rs[2*OPW-1:OPW] | out_rs[3*OPW-1:2*OPW], '0);
        check("rst_out_v0", out_v0, '0);
        check("rst_out_tag", out_tag, 8'h00);
        check("rst_rsren", bank_rsren_o, 4'h0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_rsren", bank_rsren_o, 4'h0);

        // Distinct banks: everything issues together.
        run(10'h004, 10'h005, 10'h006, 3'b111, 1'b0, 8'h11, 0);
        check("t1_rsren", log_en[1], 4'b0111);
        check("t1_rsidx", log_idx[1], 32'h0001_0101);

        // All on bank 0: serialised in priority order.
        run(10'h008, 10'h00C, 10'h010, 3'b111, 1'b0, 8'h22, 0);
        for (int k = 1; k <= 3; k++) begin
            check("t2_rsren", log_en[k], 4'b0001);
            check("t2_rsidx", log_idx[k], 32'(k + 1));
        end
        check("t2_drain_rsren", log_en[4], 4'b0000);

        // rs2 only with mask: dummy bank-0 row-0 read alongside.
        run(10'h3FE, 10'h001, 10'h2AB, 3'b010, 1'b1, 8'h33, 0);
        check("t3_rsren", log_en[1], 4'b0011);
        check("t3_rsidx", log_idx[1], 32'h0000_0000);
        check("t3_rsren_after", log_en[2], 4'b0000);

        // Backpressure in OUT.
        run(10'h123, 10'h2F1, 10'h0A2, 3'b111, 1'b1, 8'h44, 4);

        // Reset in the middle of a conflicting instruction.
        salt = $urandom;
        offer(10'h008, 10'h00C, 10'h010, 3'b111, 1'b0, 8'h55);
        check("t5_issuing", bank_rsren_o, 4'b0001);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rsren", bank_rsren_o, 4'h0);
        check("t5_rsidx", bank_rsidx_o, 32'h0);
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_out_rs", out_rs[OPW-1:0] | out_rs[2*OPW-1:OPW] | out_rs[3*OPW-1:2*OPW], '0);
        check("t5_out_v0", out_v0, '0);
        check("t5_out_tag", out_tag, 8'h00);
        check("t5_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rel_rsren", bank_rsren_o, 4'h0);
        check("t5_rel_in_ready", in_ready, 1'b1);
        run(10'h040, 10'h041, 10'h044, 3'b111, 1'b1, 8'h66, 1);

        // Degenerate: nothing to read.
        run(10'h000, 10'h000, 10'h000, 3'b000, 1'b0, 8'h77, 0);

        for (int t = 0; t < 50; t++) begin
            run(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
